// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE -> REQ (fetch) -> EXEC loop with PC-relative conditional branches.
// Latency: 2 cycles per instruction minimum (REQ with immediate ack, then EXEC); each ack-wait cycle adds one.
// Backpressure: imem_ack gates REQ, stall holds EXEC; optional PC_SEQUENCER_RETIRE_CNT_EN enables retired_cnt.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        Branch,
  input  logic        EQ,
  input  logic [31:0] ImmOp,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] PC,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        misalign,
  output logic [31:0] retired_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_EXEC = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] instr_nxt;
  logic        valid_nxt;
  logic        mis_nxt;

  // Candidate next PCs; the branch target is relative to the executing
  // instruction's own PC, not the sequential PC+4. Both wrap modulo 2^32.
  logic [31:0] seq_pc;
  logic [31:0] br_target;
  logic        take_branch;

  // Next-PC candidates and branch decision
  always_comb begin
    seq_pc      = PC + 32'd4;
    br_target   = PC + ImmOp;
    take_branch = Branch & EQ;
  end

  // Next-state and next-register-value decode; imem_req depends on state only
  always_comb begin
    state_nxt = state;
    pc_nxt    = PC;
    instr_nxt = instr;
    valid_nxt = 1'b0;
    mis_nxt   = misalign;
    imem_req  = 1'b0;
    case (state)
      ST_IDLE: begin
        state_nxt = ST_REQ;
      end
      ST_REQ: begin
        imem_req = 1'b1;
        // An ack outside REQ never reaches this branch, so it cannot capture.
        if (imem_ack) begin
          instr_nxt = imem_rdata;
          valid_nxt = 1'b1;
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!stall) begin
          state_nxt = ST_REQ;
          if (take_branch) begin
            // Word-align the target; remember that an unaligned one was seen.
            pc_nxt = {br_target[31:2], 2'b00};
            if (br_target[1:0] != 2'b00) begin
              mis_nxt = 1'b1;
            end
          end else begin
            pc_nxt = seq_pc;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset wins over every other input
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      PC          <= RESET_PC;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      misalign    <= 1'b0;
    end else begin
      state       <= state_nxt;
      PC          <= pc_nxt;
      instr       <= instr_nxt;
      instr_valid <= valid_nxt;
      misalign    <= mis_nxt;
    end
  end

`ifdef PC_SEQUENCER_RETIRE_CNT_EN
  logic        retire;
  logic [31:0] retired_q;

  // An instruction retires on every non-stalled EXEC cycle
  always_comb begin
    retire = (state == ST_EXEC) && !stall;
  end

  // Free-running retire counter, wraps silently at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= 32'h0;
    end else if (retire) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign retired_cnt = retired_q;
`else
  assign retired_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed instruction table, reset corner cases,
// then randomized instructions checked against an instruction-level PC model.
// Counter expectations follow PC_SEQUENCER_RETIRE_CNT_EN when it is defined.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        Branch;
  logic        EQ;
  logic [31:0] ImmOp;
  logic        stall;
  logic        imem_req;
  logic [31:0] PC;
  logic [31:0] instr;
  logic        instr_valid;
  logic        misalign;
  logic [31:0] retired_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: architectural state at instruction granularity
  logic [31:0] m_pc;
  logic        m_mis;
  logic [31:0] m_ret;

  typedef struct {
    int          wt;
    int          st;
    logic        br;
    logic        eq;
    logic [31:0] imm;
    logic [31:0] rd;
    logic [31:0] exp_pc;
    logic        exp_mis;
  } vec_t;

  vec_t tbl[13];

  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .Branch      (Branch),
    .EQ          (EQ),
    .ImmOp       (ImmOp),
    .stall       (stall),
    .imem_req    (imem_req),
    .PC          (PC),
    .instr       (instr),
    .instr_valid (instr_valid),
    .misalign    (misalign),
    .retired_cnt (retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_ret();
`ifdef PC_SEQUENCER_RETIRE_CNT_EN
    return m_ret;
`else
    return 32'h0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction starting with the DUT in its fetch phase.
  task automatic run_instr(input int wt, input int st, input logic br, input logic eq,
                           input logic [31:0] imm, input logic [31:0] rd);
    logic [31:0] raw;
    logic [31:0] pc_before;
    pc_before = m_pc;
    for (int w = 0; w < wt; w++) begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      chk1("wait_req", imem_req, 1'b1);
      chk("wait_pc", PC, m_pc);
      tick();
      chk1("wait_valid", instr_valid, 1'b0);
    end
    imem_ack   = 1'b1;
    imem_rdata = rd;
    chk1("fetch_req", imem_req, 1'b1);
    chk("fetch_pc", PC, m_pc);
    tick();
    chk("cap_instr", instr, rd);
    chk1("cap_valid", instr_valid, 1'b1);
    chk1("exec_req", imem_req, 1'b0);
    Branch     = br;
    EQ         = eq;
    ImmOp      = imm;
    imem_ack   = 1'($urandom_range(0, 1));
    imem_rdata = $urandom;
    for (int s = 0; s < st; s++) begin
      stall = 1'b1;
      tick();
      chk("stall_pc", PC, pc_before);
      chk("stall_instr", instr, rd);
      chk1("stall_valid", instr_valid, 1'b0);
      chk1("stall_req", imem_req, 1'b0);
      chk("stall_ret", retired_cnt, exp_ret());
      imem_ack = 1'($urandom_range(0, 1));
    end
    stall = 1'b0;
    tick();
    if (br && eq) begin
      raw  = m_pc + imm;
      m_pc = raw & 32'hFFFF_FFFC;
      if (raw % 4 != 0) m_mis = 1'b1;
    end else begin
      m_pc = m_pc + 32'd4;
    end
    m_ret = m_ret + 32'd1;
    imem_ack = 1'b0;
    chk("next_pc", PC, m_pc);
    chk1("next_mis", misalign, m_mis);
    chk("next_ret", retired_cnt, exp_ret());
    chk("next_instr", instr, rd);
    chk1("next_valid", instr_valid, 1'b0);
    chk1("next_req", imem_req, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{0, 0, 1'b0, 1'b1, 32'h0000_0040, 32'hA000_0001, 32'h0000_0004, 1'b0};
    tbl[1]  = '{0, 0, 1'b0, 1'b0, 32'h0000_0000, 32'hA000_0002, 32'h0000_0008, 1'b0};
    tbl[2]  = '{0, 0, 1'b0, 1'b0, 32'h0000_0000, 32'hA000_0003, 32'h0000_000C, 1'b0};
    tbl[3]  = '{3, 0, 1'b0, 1'b1, 32'h0000_0010, 32'hA000_0004, 32'h0000_0010, 1'b0};
    tbl[4]  = '{0, 0, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'hA000_0005, 32'h0000_0014, 1'b0};
    tbl[5]  = '{1, 0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'hA000_0006, 32'h0000_0010, 1'b0};
    tbl[6]  = '{0, 0, 1'b1, 1'b1, 32'hFFFF_FFF8, 32'hA000_0007, 32'h0000_0008, 1'b0};
    tbl[7]  = '{0, 5, 1'b0, 1'b1, 32'h0000_0064, 32'hA000_0008, 32'h0000_000C, 1'b0};
    tbl[8]  = '{0, 1, 1'b1, 1'b1, 32'h0000_0014, 32'hA000_0009, 32'h0000_0020, 1'b0};
    tbl[9]  = '{0, 0, 1'b1, 1'b1, 32'h0000_0006, 32'hA000_000A, 32'h0000_0024, 1'b1};
    tbl[10] = '{2, 2, 1'b0, 1'b0, 32'h0000_0000, 32'hA000_000B, 32'h0000_0028, 1'b1};
    tbl[11] = '{0, 0, 1'b1, 1'b1, 32'hFFFF_FFD4, 32'hA000_000C, 32'hFFFF_FFFC, 1'b1};
    tbl[12] = '{0, 0, 1'b0, 1'b0, 32'h0000_0000, 32'hA000_000D, 32'h0000_0000, 1'b1};

    // Reset for two cycles with ack and stall asserted to show reset dominates
    rst        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    Branch     = 1'b1;
    EQ         = 1'b1;
    ImmOp      = 32'h0000_0100;
    stall      = 1'b1;
    tick();
    tick();
    rst      = 1'b0;
    imem_ack = 1'b0;
    stall    = 1'b0;
    Branch   = 1'b0;
    EQ       = 1'b0;
    chk1("rst_req", imem_req, 1'b0);
    chk("rst_pc", PC, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk1("rst_valid", instr_valid, 1'b0);
    chk1("rst_mis", misalign, 1'b0);
    chk("rst_ret", retired_cnt, 32'h0);
    tick();
    chk1("idle_to_req", imem_req, 1'b1);
    chk("idle_pc", PC, 32'h0);

    m_pc  = 32'h0;
    m_mis = 1'b0;
    m_ret = 32'h0;

    // Directed instruction table
    for (int i = 0; i < 13; i++) begin
      run_instr(tbl[i].wt, tbl[i].st, tbl[i].br, tbl[i].eq, tbl[i].imm, tbl[i].rd);
      chk("vec_pc", PC, tbl[i].exp_pc);
      chk1("vec_mis", misalign, tbl[i].exp_mis);
    end

    // Reset while fetching, then a late ack while IDLE must not capture
    rst        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    rst = 1'b0;
    chk1("rreq_req", imem_req, 1'b0);
    chk("rreq_pc", PC, 32'h0);
    chk("rreq_instr", instr, 32'h0);
    chk1("rreq_mis", misalign, 1'b0);
    chk("rreq_ret", retired_cnt, 32'h0);
    tick();
    chk("late_ack_instr", instr, 32'h0);
    chk1("late_ack_valid", instr_valid, 1'b0);
    chk1("late_ack_req", imem_req, 1'b1);
    chk("late_ack_pc", PC, 32'h0);
    imem_ack = 1'b0;
    m_pc  = 32'h0;
    m_mis = 1'b0;
    m_ret = 32'h0;

    // Randomized instruction stream against the reference model
    for (int n = 0; n < 150; n++) begin
      int          t;
      logic [31:0] imm;
      if ($urandom_range(0, 3) == 0) begin
        imm = $urandom;
      end else begin
        t   = int'($urandom_range(0, 64)) - 32;
        imm = 32'(t);
      end
      run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), imm, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: program counter value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 imem_ack  input  1  instruction memory returns imem_rdata this cycle.
REQ-005 imem_rdata  input  32  instruction word, valid only when imem_ack=1.
REQ-006 Branch  input  1  decoded current instruction is a conditional branch.
REQ-007 EQ  input  1  ALU zero flag for current instruction.
REQ-008 ImmOp  input  32  sign-extended branch offset, in bytes.
REQ-009 stall  input  1  holds the sequencer in EXEC.
REQ-010 imem_req  output  1  fetch request to instruction memory.
REQ-011 PC  output  32  address of current/requested instruction; also imem address.
REQ-012 instr  output  32  registered instruction word.
REQ-013 instr_valid  output  1  one-cycle pulse: instr newly captured.
REQ-014 misalign  output  1  sticky flag: a taken branch target had PC-relative bits [1:0] != 0.
REQ-015 retired_cnt  output  32  count of instructions leaving EXEC (see Configuration).

Function
REQ-016 FSM states IDLE, REQ, EXEC; exactly one active; encoding free.
REQ-017 IDLE: imem_req=0; unconditional transition to REQ next cycle.
REQ-018 REQ: imem_req=1, PC held; on imem_ack=1, instr<=imem_rdata, instr_valid=1 next cycle, go EXEC; else remain REQ.
REQ-019 imem_ack while not in REQ shall be ignored; instr unchanged.
REQ-020 EXEC: imem_req=0; instr_valid=1 only on first EXEC cycle.
REQ-021 EXEC with stall=1: PC, instr, state held; no counter update.
REQ-022 EXEC with stall=0: PC <= (Branch & EQ) ? PC+ImmOp : PC+4; state -> REQ next cycle.
REQ-023 Branch target uses PC of the executing instruction, not PC+4.
REQ-024 PC arithmetic 32-bit modulo 2^32; wrap-around silent (32'hFFFF_FFFC + 4 = 0).
REQ-025 Taken target bits [1:0] forced to 2'b00 in PC; misalign set to 1 if raw target[1:0] != 0; cleared only by rst.
REQ-026 Branch=0 shall ignore EQ and ImmOp entirely.
REQ-027 Minimum cycles per instruction: 2 (REQ with immediate ack, EXEC); each ack-wait cycle adds one.
REQ-028 Outputs fully registered except imem_req, which is decoded from state only.

Reset
REQ-029 On rst=1: state=IDLE, PC=RESET_PC, instr=0, instr_valid=0, misalign=0, retired_cnt=0, imem_req=0 next cycle.
REQ-030 rst overrides all inputs, including imem_ack and stall in the same cycle.
REQ-031 rst mid-REQ: pending fetch abandoned; a late imem_ack after reset shall not capture (state is IDLE).

Configuration
REQ-032 Macro PC_SEQUENCER_RETIRE_CNT_EN defined: retired_cnt increments by 1 on every EXEC cycle with stall=0, wrapping at 2^32.
REQ-033 Macro undefined: counter logic absent; retired_cnt tied to 32'h0; port still present.

Verification
REQ-034 rst 2 cycles, then imem_ack=1 in every REQ, Branch=0: PC sequence 0,4,8,12; instr_valid pulses once per 2 cycles.
REQ-035 PC=0x10, Branch=1, EQ=1, ImmOp=-8 -> next PC=0x08; EQ=0 -> next PC=0x14.
REQ-036 imem_ack held low 3 cycles in REQ -> PC stable, imem_req=1 throughout, capture on 4th cycle with ack.
REQ-037 stall=1 for 5 EXEC cycles -> PC, instr unchanged, instr_valid single pulse, retired_cnt unchanged (macro on).
REQ-038 PC=0x20, Branch=1, EQ=1, ImmOp=6 -> PC=0x24, misalign=1 and stays 1 until rst.
REQ-039 rst asserted in REQ, imem_ack=1 next cycle -> instr stays 0, PC=RESET_PC, state IDLE then REQ.
